month_year: RTL and testbench
=============================

Name: month_year

Overview:
- Calendar stage downstream of the day counter in the millennium clock.
- Consumes the day-overflow pulse; counts month 1..12 and year 0..YEAR_MAX.
- Supplies month_bin and leap_year back to the day counter for its month-length decode.
- Supports manual month/year adjustment with up/down buttons.

Parameters:
- YEAR_MAX, 9999: last year before wrap to 0.
- YEAR_RESET, 2000: year loaded on reset.
- MONTH_RESET, 1: month loaded on reset; legal range 1..12.

Ports:
- clk_1Hz  input  1  system tick clock.
- rst_n  input  1  reset, asynchronous, active-low.
- en_1  input  1  count enable.
- carry_in  input  1  one-cycle day-overflow pulse from the day counter.
- adjust  input  1  0 = count mode, 1 = adjust mode.
- sel  input  1  adjust field select: 0 = month, 1 = year.
- up  input  1  increment button, level, synchronous to clk_1Hz.
- down  input  1  decrement button, level, synchronous to clk_1Hz.
- month_bin  output  4  current month, 1..12.
- year_bin  output  14  current year, 0..YEAR_MAX.
- leap_year  output  1  current year is a leap year.
- carry_out  output  1  one-cycle pulse on year wrap YEAR_MAX -> 0.

Behaviour:
- Clocking and reset
  - Single clock domain; all state changes on the posedge of clk_1Hz.
  - Reset is asynchronous, active-low.
  - Reset values: month_bin = MONTH_RESET, year_bin = YEAR_RESET, carry_out = 0, up_q = 0, down_q = 0.
- Button edge detection
  - up_q and down_q register up and down every cycle, in every mode.
  - up_rise = up & ~up_q; down_rise = down & ~down_q.
  - A button already held when adjust rises produces no step.
- Count mode (adjust = 0)
  - Step condition: en_1 & carry_in.
  - month < 12: month_bin + 1 on the next edge; year unchanged; carry_out = 0.
  - month = 12: month_bin = 1 and year_bin + 1.
  - If year_bin = YEAR_MAX at that step, year_bin wraps to 0 and carry_out = 1 for exactly that cycle.
  - carry_out is 0 on every cycle without a wrap.
  - up/down have no effect in count mode.
- Adjust mode (adjust = 1)
  - carry_in and en_1 are ignored; carry_out is held 0.
  - up_rise & down_rise in the same cycle: no change.
  - sel = 0: up_rise steps month +1 with 12 -> 1; down_rise steps month -1 with 1 -> 12. Year is untouched; a month wrap never carries into the year.
  - sel = 1: up_rise steps year +1 with YEAR_MAX -> 0; down_rise steps year -1 with 0 -> YEAR_MAX. carry_out is not asserted.
  - sel changes take effect on the same cycle they are sampled.
- Output timing
  - Register outputs update one edge after the qualifying input.
  - leap_year is combinational from year_bin, so it is valid in the same cycle as year_bin.
- leap_year rule
  - Base rule: year_bin mod 4 = 0.
  - Year 0 is leap.
  - The mod-4 test is bits [1:0] = 0; no divider.
- Mode switching and reset
  - Toggling adjust mid-count loses no state.
  - A carry_in coincident with adjust = 1 is dropped, not deferred.
  - Reset asserted mid-operation immediately forces the reset values, including clearing a pending carry_out.

Optional Feature:
- Macro: LEAP_GREGORIAN_EN.
- Defined: full Gregorian rule, leap = (y mod 4 = 0 and y mod 100 != 0) or y mod 400 = 0.
  - Implemented with a registered mod-100/mod-400 decode updated whenever year_bin changes.
  - leap_year may lag year_bin by at most one cycle after a year change.
  - The decode settles before the next carry_in, since a month lasts at least 28 days.
- Undefined: mod-4 rule only, purely combinational, no extra registers.

Test Plan:
- Reset: release rst_n -> month_bin = 1, year_bin = 2000, leap_year = 1, carry_out = 0.
- Year rollover: adjust to month 12, year 2023; adjust = 0; one carry_in with en_1 = 1 -> month_bin = 1, year_bin = 2024, leap_year = 1, carry_out = 0.
- Millennium wrap: set month 12, year 9999; one carry_in -> month_bin = 1, year_bin = 0, carry_out = 1 for one cycle then 0.
- Adjust wraps: sel = 0, month 1, down pulse -> 12; sel = 1, year 0, down pulse -> 9999.
  - up and down rising together -> no change.
  - carry_in during adjust -> no change.
  - up held across adjust 0 -> 1 -> no step.
- Leap decode: year 1900 -> leap_year = 1 without LEAP_GREGORIAN_EN, 0 with it.
  - Year 2000 -> 1 in both builds.
  - Year 2023 -> 0 in both builds.
- Async reset: assert rst_n low between clock edges while adjusting month to 7, year to 2100 -> outputs return to 1 and 2000 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/month_year.sv
// month_year: calendar stage below the day counter. Counts month 1..12 and
// year 0..YEAR_MAX on the day-overflow pulse. Also supports manual up/down
// adjustment of the month or the year.
// Optional build macro LEAP_GREGORIAN_EN: when it is defined, leap_year uses
// the full Gregorian rule through a registered decode. Otherwise leap_year
// uses the combinational mod-4 rule.
module month_year #(
    parameter int unsigned YEAR_MAX    = 9999,
    parameter int unsigned YEAR_RESET  = 2000,
    parameter int unsigned MONTH_RESET = 1
) (
    input  logic        clk_1Hz,
    input  logic        rst_n,
    input  logic        en_1,
    input  logic        carry_in,
    input  logic        adjust,
    input  logic        sel,
    input  logic        up,
    input  logic        down,
    output logic [3:0]  month_bin,
    output logic [13:0] year_bin,
    output logic        leap_year,
    output logic        carry_out
);

    localparam logic [13:0] C_YEAR_MAX    = 14'(YEAR_MAX);
    localparam logic [13:0] C_YEAR_RESET  = 14'(YEAR_RESET);
    localparam logic [3:0]  C_MONTH_RESET = 4'(MONTH_RESET);

    logic [3:0]  r_month;
    logic [13:0] r_year;
    logic        r_carry;
    logic        r_up_q;
    logic        r_down_q;

    logic        w_up_rise;
    logic        w_down_rise;
    logic [3:0]  w_month_nxt;
    logic [13:0] w_year_nxt;
    logic        w_carry_nxt;

    assign w_up_rise   = up & ~r_up_q;
    assign w_down_rise = down & ~r_down_q;

    // Next month/year/carry from count mode or from adjust-mode button edges.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves it unassigned and no latch is inferred.
        w_month_nxt = r_month;
        w_year_nxt  = r_year;
        w_carry_nxt = 1'b0;
        if (!adjust) begin
            if (en_1 && carry_in) begin
                if (r_month == 4'd12) begin
                    w_month_nxt = 4'd1;
                    if (r_year == C_YEAR_MAX) begin
                        w_year_nxt  = '0;
                        w_carry_nxt = 1'b1;
                    end else begin
                        w_year_nxt = r_year + 14'd1;
                    end
                end else begin
                    w_month_nxt = r_month + 4'd1;
                end
            end
        end else if (w_up_rise != w_down_rise) begin
            // Two simultaneous edges cancel each other. A month wrap never touches the year.
            if (!sel) begin
                if (w_up_rise) begin
                    w_month_nxt = (r_month == 4'd12) ? 4'd1 : r_month + 4'd1;
                end else begin
                    w_month_nxt = (r_month == 4'd1) ? 4'd12 : r_month - 4'd1;
                end
            end else begin
                if (w_up_rise) begin
                    w_year_nxt = (r_year == C_YEAR_MAX) ? 14'd0 : r_year + 14'd1;
                end else begin
                    w_year_nxt = (r_year == 14'd0) ? C_YEAR_MAX : r_year - 14'd1;
                end
            end
        end
    end

    // Calendar state and button history. The button history is sampled in every mode.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_month  <= C_MONTH_RESET;
            r_year   <= C_YEAR_RESET;
            r_carry  <= 1'b0;
            r_up_q   <= 1'b0;
            r_down_q <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments, so every register samples the values from before this edge.
            r_month  <= w_month_nxt;
            r_year   <= w_year_nxt;
            r_carry  <= w_carry_nxt;
            r_up_q   <= up;
            r_down_q <= down;
        end
    end

`ifdef LEAP_GREGORIAN_EN
    function automatic logic greg_leap(input logic [13:0] y);
        return ((y[1:0] == 2'b00) && ((y % 14'd100) != 14'd0)) ||
               ((y % 14'd400) == 14'd0);
    endfunction

    localparam logic C_LEAP_RESET = greg_leap(C_YEAR_RESET);

    logic r_leap;

    // Registered Gregorian decode. It lags a year change by one cycle and has
    // settled long before the next month step.
    always_ff @(posedge clk_1Hz or negedge rst_n) begin
        if (!rst_n) begin
            r_leap <= C_LEAP_RESET;
        end else begin
            r_leap <= greg_leap(r_year);
        end
    end

    assign leap_year = r_leap;
`else
    assign leap_year = (r_year[1:0] == 2'b00);
`endif

    assign month_bin = r_month;
    assign year_bin  = r_year;
    assign carry_out = r_carry;

endmodule

// File: tb/tb_month_year.sv
// Testbench for month_year. It checks directed scenarios and random stimulus
// against a calendar model written as plain arithmetic.
module tb_month_year;

    localparam int YMAX = 9999;

    logic        clk_1Hz = 1'b0;
    logic        rst_n;
    logic        en_1, carry_in, adjust, sel, up, down;
    logic [3:0]  month_bin;
    logic [13:0] year_bin;
    logic        leap_year, carry_out;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state.
    int m_month, m_year;
    bit m_carry, m_up_q, m_down_q;

    month_year dut (
        .clk_1Hz  (clk_1Hz),
        .rst_n    (rst_n),
        .en_1     (en_1),
        .carry_in (carry_in),
        .adjust   (adjust),
        .sel      (sel),
        .up       (up),
        .down     (down),
        .month_bin(month_bin),
        .year_bin (year_bin),
        .leap_year(leap_year),
        .carry_out(carry_out)
    );

    always #5 clk_1Hz = ~clk_1Hz;

    function automatic bit leap_of(input int y);
`ifdef LEAP_GREGORIAN_EN
        return ((y % 4 == 0) && (y % 100 != 0)) || (y % 400 == 0);
`else
        return (y % 4 == 0);
`endif
    endfunction

    task automatic model_reset();
        m_month = 1; m_year = 2000; m_carry = 0; m_up_q = 0; m_down_q = 0;
    endtask

    // Drive one cycle of inputs, advance the model, then return at the next negedge.
    task automatic tick(input bit en, input bit cin, input bit adj, input bit s,
                        input bit u, input bit d);
        bit ur, dr;
        int months;
        en_1 = en; carry_in = cin; adjust = adj; sel = s; up = u; down = d;
        ur = u && !m_up_q;
        dr = d && !m_down_q;
        m_carry = 0;
        if (!adj) begin
            if (en && cin) begin
                months = m_year * 12 + m_month;   // month index after the step
                m_month = months % 12 + 1;
                m_year  = months / 12;
                if (m_year > YMAX) begin
                    m_year = 0; m_carry = 1;
                end
            end
        end else if (ur != dr) begin
            if (!s) m_month = ((m_month - 1 + (ur ? 1 : 11)) % 12) + 1;
            else    m_year  = (m_year + (ur ? 1 : YMAX)) % (YMAX + 1);
        end
        m_up_q = u; m_down_q = d;
        @(posedge clk_1Hz);
        @(negedge clk_1Hz);
    endtask

    // Walk month and year to a target in adjust mode, taking the shorter direction.
    task automatic goto(input int mo, input int yr);
        int fwd;
        while (m_month != mo) begin
            fwd = (mo - m_month + 12) % 12;
            tick(0, 0, 1, 0, fwd <= 6, fwd > 6);
            tick(0, 0, 1, 0, 0, 0);
        end
        while (m_year != yr) begin
            fwd = (yr - m_year + YMAX + 1) % (YMAX + 1);
            tick(0, 0, 1, 1, fwd <= (YMAX + 1) / 2, fwd > (YMAX + 1) / 2);
            tick(0, 0, 1, 1, 0, 0);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en_1 = 0; carry_in = 0; adjust = 0; sel = 0; up = 0; down = 0;
        model_reset();
        repeat (2) @(negedge clk_1Hz);
        rst_n = 1'b1;
        n_total++; if (month_bin !== 4'd1) $display("FAIL reset_month got %0d exp 1", month_bin); else n_pass++;
        n_total++; if (year_bin !== 14'd2000) $display("FAIL reset_year got %0d exp 2000", year_bin); else n_pass++;
        n_total++; if (leap_year !== 1'b1) $display("FAIL reset_leap got %0b exp 1", leap_year); else n_pass++;
        n_total++; if (carry_out !== 1'b0) $display("FAIL reset_carry got %0b exp 0", carry_out); else n_pass++;
    endtask

    task automatic test_year_rollover();
        goto(12, 2023);
        n_total++; if (month_bin !== 4'd12 || year_bin !== 14'd2023)
            $display("FAIL adjust_setup got %0d/%0d exp 12/2023", month_bin, year_bin); else n_pass++;
        tick(1, 1, 0, 0, 0, 0);
        n_total++; if (month_bin !== 4'd1) $display("FAIL rollover_month got %0d exp 1", month_bin); else n_pass++;
        n_total++; if (year_bin !== 14'd2024) $display("FAIL rollover_year got %0d exp 2024", year_bin); else n_pass++;
        n_total++; if (carry_out !== 1'b0) $display("FAIL rollover_carry got %0b exp 0", carry_out); else n_pass++;
        tick(0, 0, 0, 0, 0, 0);
        n_total++; if (leap_year !== 1'b1) $display("FAIL rollover_leap got %0b exp 1", leap_year); else n_pass++;
        // Carry_in without en_1 must not count.
        tick(0, 1, 0, 0, 0, 0);
        n_total++; if (month_bin !== 4'd1) $display("FAIL no_en_month got %0d exp 1", month_bin); else n_pass++;
    endtask

    task automatic test_millennium_wrap();
        goto(12, YMAX);
        tick(1, 1, 0, 0, 0, 0);
        n_total++; if (month_bin !== 4'd1 || year_bin !== 14'd0)
            $display("FAIL wrap_value got %0d/%0d exp 1/0", month_bin, year_bin); else n_pass++;
        n_total++; if (carry_out !== 1'b1) $display("FAIL wrap_carry got %0b exp 1", carry_out); else n_pass++;
        tick(0, 0, 0, 0, 0, 0);
        n_total++; if (carry_out !== 1'b0) $display("FAIL wrap_carry_clear got %0b exp 0", carry_out); else n_pass++;
        n_total++; if (leap_year !== 1'b1) $display("FAIL year0_leap got %0b exp 1", leap_year); else n_pass++;
    endtask

    task automatic test_adjust_wraps();
        goto(1, 0);
        tick(0, 0, 1, 0, 0, 1);
        n_total++; if (month_bin !== 4'd12 || year_bin !== 14'd0)
            $display("FAIL month_down_wrap got %0d/%0d exp 12/0", month_bin, year_bin); else n_pass++;
        tick(0, 0, 1, 1, 0, 0);
        tick(0, 0, 1, 1, 0, 1);
        n_total++; if (year_bin !== 14'(YMAX) || carry_out !== 1'b0)
            $display("FAIL year_down_wrap got %0d carry %0b exp 9999 carry 0", year_bin, carry_out); else n_pass++;
        tick(0, 0, 1, 1, 0, 0);
        tick(0, 0, 1, 1, 1, 0);
        n_total++; if (year_bin !== 14'd0 || carry_out !== 1'b0)
            $display("FAIL year_up_wrap got %0d carry %0b exp 0 carry 0", year_bin, carry_out); else n_pass++;
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 1, 0);
        n_total++; if (month_bin !== 4'd1 || year_bin !== 14'd0)
            $display("FAIL month_up_wrap got %0d/%0d exp 1/0", month_bin, year_bin); else n_pass++;
        tick(0, 0, 1, 0, 0, 0);
        tick(0, 0, 1, 0, 1, 1);
        n_total++; if (month_bin !== 4'd1) $display("FAIL both_buttons got %0d exp 1", month_bin); else n_pass++;
        tick(0, 0, 1, 0, 0, 0);
        tick(1, 1, 1, 0, 0, 0);
        n_total++; if (month_bin !== 4'd1 || year_bin !== 14'd0)
            $display("FAIL carry_in_adjust got %0d/%0d exp 1/0", month_bin, year_bin); else n_pass++;
        tick(0, 0, 0, 0, 1, 0);
        n_total++; if (month_bin !== 4'd1) $display("FAIL up_in_count got %0d exp 1", month_bin); else n_pass++;
        tick(0, 0, 1, 0, 1, 0);
        n_total++; if (month_bin !== 4'd1) $display("FAIL up_held_into_adjust got %0d exp 1", month_bin); else n_pass++;
        tick(0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_leap_decode();
        goto(m_month, 1900);
        tick(0, 0, 1, 0, 0, 0);
`ifdef LEAP_GREGORIAN_EN
        n_total++; if (leap_year !== 1'b0) $display("FAIL leap_1900 got %0b exp 0", leap_year); else n_pass++;
`else
        n_total++; if (leap_year !== 1'b1) $display("FAIL leap_1900 got %0b exp 1", leap_year); else n_pass++;
`endif
        goto(m_month, 2000);
        tick(0, 0, 1, 0, 0, 0);
        n_total++; if (leap_year !== 1'b1) $display("FAIL leap_2000 got %0b exp 1", leap_year); else n_pass++;
        goto(m_month, 2023);
        tick(0, 0, 1, 0, 0, 0);
        n_total++; if (leap_year !== 1'b0) $display("FAIL leap_2023 got %0b exp 0", leap_year); else n_pass++;
    endtask

    task automatic test_random();
        int prev_year;
        int errs = 0;
        for (int i = 0; i < 400; i++) begin
            prev_year = m_year;
            tick($urandom_range(3, 0) != 0, $urandom_range(1, 0) == 1, $urandom_range(2, 0) == 0,
                 $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1);
            n_total++;
            if (month_bin !== 4'(m_month) || year_bin !== 14'(m_year) || carry_out !== m_carry ||
                (m_year == prev_year && leap_year !== leap_of(m_year))) begin
                if (errs < 10)
                    $display("FAIL random[%0d] got m%0d y%0d c%0b l%0b exp m%0d y%0d c%0b l%0b", i,
                             month_bin, year_bin, carry_out, leap_year, m_month, m_year, m_carry, leap_of(m_year));
                errs++;
            end else n_pass++;
        end
    endtask

    task automatic test_async_reset();
        goto(7, 2100);
        n_total++; if (month_bin !== 4'd7 || year_bin !== 14'd2100)
            $display("FAIL pre_reset got %0d/%0d exp 7/2100", month_bin, year_bin); else n_pass++;
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        n_total++; if (month_bin !== 4'd1 || year_bin !== 14'd2000 || carry_out !== 1'b0 || leap_year !== 1'b1)
            $display("FAIL async_reset got m%0d y%0d c%0b l%0b exp m1 y2000 c0 l1",
                     month_bin, year_bin, carry_out, leap_year); else n_pass++;
        @(negedge clk_1Hz);
        rst_n = 1'b1;
        tick(1, 1, 0, 0, 0, 0);
        n_total++; if (month_bin !== 4'd2 || year_bin !== 14'd2000)
            $display("FAIL after_reset got %0d/%0d exp 2/2000", month_bin, year_bin); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_year_rollover();
        test_millennium_wrap();
        test_adjust_wraps();
        test_leap_decode();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
